// File: rtl/instr_encoder.sv
// instr_encoder: single-register-stage RV32I instruction encoder with a running byte-address counter.
// Defining INSTR_ENCODER_IMM_CHECK_EN flags immediates that do not fit their format.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_op,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        out_err
);

   typedef enum logic [3:0] {
      FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_FIX, FMT_ILL
   } fmt_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
   localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
   localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

   fmt_t        fmt;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] fixed_word;
   logic [31:0] enc_word;
   logic        enc_err;
   logic        accept;
   logic        xfer;

   // Handshake: a side transfers when its valid and ready are both high in the same cycle.
   // Ready is held low during reset and clear so nothing is taken while state is being wiped.
   assign in_ready = rst_n && !clr && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;

   // Operation decode into format, major opcode and function fields.
   always_comb begin
      fmt        = FMT_ILL;
      opc        = OPC_OPIMM;
      f3         = 3'b000;
      f7         = 7'b0000000;
      fixed_word = NOP_WORD;
      case (in_op)
         6'd0:  begin fmt = FMT_U;  opc = OPC_LUI;    end
         6'd1:  begin fmt = FMT_U;  opc = OPC_AUIPC;  end
         6'd2:  begin fmt = FMT_J;  opc = OPC_JAL;    end
         6'd3:  begin fmt = FMT_I;  opc = OPC_JALR;   f3 = 3'b000; end
         6'd4:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b000; end
         6'd5:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b001; end
         6'd6:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b100; end
         6'd7:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b101; end
         6'd8:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b110; end
         6'd9:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b111; end
         6'd10: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b000; end
         6'd11: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b001; end
         6'd12: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b010; end
         6'd13: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b100; end
         6'd14: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b101; end
         6'd15: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'b000; end
         6'd16: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'b001; end
         6'd17: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'b010; end
         6'd18: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b000; end
         6'd19: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b010; end
         6'd20: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b011; end
         6'd21: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b100; end
         6'd22: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b110; end
         6'd23: begin fmt = FMT_I;  opc = OPC_OPIMM;  f3 = 3'b111; end
         6'd24: begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'b001; end
         6'd25: begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'b101; end
         6'd26: begin fmt = FMT_SH; opc = OPC_OPIMM;  f3 = 3'b101; f7 = F7_ALT; end
         6'd27: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b000; end
         6'd28: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b000; f7 = F7_ALT; end
         6'd29: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b001; end
         6'd30: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b010; end
         6'd31: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b011; end
         6'd32: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b100; end
         6'd33: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b101; end
         6'd34: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b101; f7 = F7_ALT; end
         6'd35: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b110; end
         6'd36: begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b111; end
         6'd37: begin fmt = FMT_I;  opc = OPC_FENCE;  f3 = 3'b000; end
         6'd38: begin fmt = FMT_FIX; fixed_word = ECALL_WORD;  end
         6'd39: begin fmt = FMT_FIX; fixed_word = EBREAK_WORD; end
         default: fmt = FMT_ILL;
      endcase
   end

   // Word assembly; immediates outside the field width are truncated.
   always_comb begin
      enc_word = NOP_WORD;
      case (fmt)
         FMT_R:   enc_word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
         FMT_SH:  enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
         FMT_I:   enc_word = {in_imm[11:0], in_rs1, f3, in_rd, opc};
         FMT_S:   enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
         FMT_B:   enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                              in_imm[4:1], in_imm[11], opc};
         FMT_U:   enc_word = {in_imm[31:12], in_rd, opc};
         FMT_J:   enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
         FMT_FIX: enc_word = fixed_word;
         default: enc_word = NOP_WORD;
      endcase
   end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
   logic i_bad;
   logic b_bad;
   logic j_bad;
   logic sh_bad;
   logic u_bad;
   logic imm_bad;

   // An immediate fits when every bit above the field's sign bit copies that sign bit.
   assign i_bad  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
   assign b_bad  = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
   assign j_bad  = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
   assign sh_bad = |in_imm[31:5];
   assign u_bad  = |in_imm[11:0];

   always_comb begin
      imm_bad = 1'b0;
      case (fmt)
         FMT_I, FMT_S: imm_bad = i_bad;
         FMT_B:        imm_bad = b_bad;
         FMT_J:        imm_bad = j_bad;
         FMT_SH:       imm_bad = sh_bad;
         FMT_U:        imm_bad = u_bad;
         default:      imm_bad = 1'b0;
      endcase
   end

   assign enc_err = (fmt == FMT_ILL) || imm_bad;
`else
   assign enc_err = (fmt == FMT_ILL);
`endif

   // Output stage and address counter; out_addr always names the word currently held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= 32'h0000_0000;
         out_err   <= 1'b0;
         out_addr  <= BASE_ADDR;
      end else if (clr) begin
         out_valid <= 1'b0;
         out_addr  <= BASE_ADDR;
      end else begin
         if (xfer)
            out_addr <= out_addr + 32'd4;
         if (accept) begin
            out_valid <= 1'b1;
            out_instr <= enc_word;
            out_err   <= enc_err;
         end else if (xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the first write address after reset or clear.
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port clr, input, 1, synchronous clear of the pipeline and address counter.
REQ-005 SHALL have port in_valid, input, 1, request holds a valid instruction description.
REQ-006 SHALL have port in_ready, output, 1, encoder accepts the request this cycle.
REQ-007 SHALL have port in_op, input, 6, operation enum: lui=0, auipc=1, jal=2, jalr=3, beq..bgeu=4..9, lb,lh,lw,lbu,lhu=10..14, sb,sh,sw=15..17, addi,slti,sltiu,xori,ori,andi=18..23, slli,srli,srai=24..26, add,sub,sll,slt,sltu,xor,srl,sra,or,and=27..36, fence=37, ecall=38, ebreak=39; 40..63 are illegal.
REQ-008 SHALL have ports in_rd, in_rs1, in_rs2, input, 5 each, register fields.
REQ-009 SHALL have port in_imm, input, 32, the full signed immediate value (shamt for shifts, pred/succ in [7:0] for fence).
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_instr (output, 32, encoded RV32I word), out_addr (output, 32, byte address of out_instr) and out_err (output, 1, encoding error flag).

Function
REQ-011 SHALL accept a request when in_valid and in_ready are both high.
REQ-012 SHALL drive in_ready = !clr && (!out_valid || out_ready), giving a single register stage with full throughput.
REQ-013 SHALL present an accepted request on out_* exactly one cycle later, registered and held stable while out_valid && !out_ready.
REQ-014 SHALL encode per RV32I base formats:
  - R: funct7=0100000 for sub/sra, otherwise 0.
  - I: imm[11:0].
  - S: imm[11:5] | imm[4:0].
  - B: imm[12|10:5], imm[4:1|11].
  - U: imm[31:12].
  - J: imm[20|10:1|11|19:12].
REQ-015 SHALL encode slli/srli/srai as shamt=imm[4:0], with funct7 0000000/0000000/0100000 respectively.
REQ-016 SHALL produce fixed words for ecall (32'h0000_0073) and ebreak (32'h0010_0073), ignoring register and imm fields.
REQ-017 SHALL encode fence with opcode 0001111, funct3 000, imm[11:0], rd and rs1.
REQ-018 SHALL, for an illegal op, emit 32'h0000_0013 (nop) with out_err=1.
REQ-019 SHALL advance the address counter by 4 on each output transfer (out_valid && out_ready) so that out_addr = BASE_ADDR + 4*transfers.
REQ-020 SHALL let the address counter wrap modulo 2^32 without error.
REQ-021 SHALL, when clr is high, drop out_valid to 0 and set the address counter to BASE_ADDR on the next edge; clr takes precedence over any simultaneous transfer or accept.
REQ-022 SHALL, when a transfer and an accept occur in the same cycle, load the new word, with out_addr advanced by 4.

Reset
REQ-023 SHALL, on rst_n low (asynchronous), immediately force out_valid=0, out_instr=0, out_err=0 and out_addr=BASE_ADDR.
REQ-024 SHALL discard any in-flight word on reset mid-operation.
REQ-025 SHALL hold in_ready low while rst_n is low and accept no request before the first rising edge after deassertion.

Configuration
REQ-026 SHALL, with macro INSTR_ENCODER_IMM_CHECK_EN defined, set out_err=1 (word still encoded by truncation) when:
  - I/S imm is not a sign-extended 12-bit value;
  - B imm is not 13-bit sign-extended, or imm[0]=1;
  - J imm is not 21-bit sign-extended, or imm[0]=1;
  - shift imm[31:5] is nonzero;
  - U imm[11:0] is nonzero.
REQ-027 SHALL, without that macro, truncate immediates silently and assert out_err only for illegal ops.

Verification
REQ-028 SHALL cover: reset, then addi rd=1 rs1=0 imm=5 with out_ready=1 -> out_instr=32'h0050_0093, out_addr=0, one cycle after accept.
REQ-029 SHALL cover: sub rd=3 rs1=1 rs2=2, then jal rd=1 imm=-4 -> out_instr 32'h4020_81B3 then 32'hFFDF_F0EF, with addresses 0 then 4.
REQ-030 SHALL cover: out_ready low for 3 cycles with a word pending -> in_ready=0 and out_* stable; releasing out_ready -> transfer plus a same-cycle accept.
REQ-031 SHALL cover: in_op=45 -> out_instr=32'h0000_0013, out_err=1; and beq imm=3 -> out_err=1 only with INSTR_ENCODER_IMM_CHECK_EN defined.
REQ-032 SHALL cover: BASE_ADDR=32'hFFFF_FFFC with two transfers -> out_addr FFFF_FFFC then 0000_0000; and clr asserted with out_valid=1 -> out_valid=0 and next out_addr=BASE_ADDR.
